// File: rtl/mem_trace_watch.sv
// Data-memory access tracer with address watchpoints and a sticky halt request.
// Latency: an access sampled at edge N is visible on trace_* after edge N (no same-cycle bypass).
// Backpressure: trace_ready throttles the drain; a push into a full FIFO with no pop is dropped and counted.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset (clears all state)
//   pc/mem_*              core data-memory port snoop: PC, strobes, address, store data, load data
//   capture_mode          0 = record every access, 1 = record watchpoint hits only
//   cfg_*                 watchpoint config write (index >= NUM_WP ignored), mode 00 off/01 rd/10 wr/11 any
//   clear                 clears halt_req, halt_wp and drop_count
//   trace_*               first-word-fall-through head of the trace FIFO plus occupancy
//   drop_count            saturating count of entries lost to a full FIFO
//   halt_req, halt_wp     sticky first-hit flag and lowest channel index of that hit

// Generic storage FIFO, first-word-fall-through, level-tracked.
// Latency: a push at edge N is at the head after edge N when the FIFO was empty.
// Backpressure: push_vld is accepted when not full or when a pop happens on the same edge.
module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_vld,
   input  logic [W-1:0]  push_dat,
   input  logic          pop_rdy,
   output logic          head_vld,
   output logic [W-1:0]  head_dat,
   output logic [LW-1:0] level,
   output logic          full
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign head_vld = (level != '0);
   assign full     = (level == LW'(DEPTH));
   assign do_pop   = pop_rdy && head_vld;
   // A pop on the same edge frees the slot being written, so full does not block.
   assign do_push  = push_vld && (!full || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

   // Storage carries no reset; head_vld qualifies its contents.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

module mem_trace_watch #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 16,
   parameter int NUM_WP = 4,
   parameter int DROP_W = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [XLEN-1:0]           pc,
   input  logic                      mem_write,
   input  logic                      mem_read,
   input  logic [XLEN-1:0]           mem_addr,
   input  logic [XLEN-1:0]           mem_wdata,
   input  logic [XLEN-1:0]           mem_rdata,
   input  logic                      capture_mode,
   input  logic                      cfg_we,
   input  logic [2:0]                cfg_idx,
   input  logic [XLEN-1:0]           cfg_addr,
   input  logic [1:0]                cfg_mode,
   input  logic                      clear,
   output logic                      trace_valid,
   input  logic                      trace_ready,
   output logic [XLEN-1:0]           trace_pc,
   output logic [XLEN-1:0]           trace_addr,
   output logic [XLEN-1:0]           trace_data,
   output logic                      trace_is_write,
   output logic [NUM_WP-1:0]         trace_wp_hit,
   output logic [$clog2(DEPTH):0]    trace_level,
   output logic [DROP_W-1:0]         drop_count,
   output logic                      halt_req,
   output logic [2:0]                halt_wp
);

   localparam int LW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   addr;
      logic [XLEN-1:0]   data;
      logic              is_write;
      logic [NUM_WP-1:0] wp_hit;
   } entry_t;

   logic [XLEN-1:0]   wp_addr [NUM_WP];
   logic [1:0]        wp_mode [NUM_WP];

   logic              access;
   logic              is_write;
   logic [NUM_WP-1:0] hit;
   logic              any_hit;
   logic [2:0]        lo_idx;
   logic              push;
   logic              pop;
   logic              full;
   logic              drop;
   entry_t            in_entry;
   entry_t            head_raw;
   entry_t            head;

   // Simultaneous strobes are treated as a store.
   assign access   = mem_write || mem_read;
   assign is_write = mem_write;

   // Watchpoint configuration; a write lands at this edge, so the hit logic
   // below only ever sees configuration from earlier cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_WP; i++) begin
            wp_addr[i] <= '0;
            wp_mode[i] <= 2'b00;
         end
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_WP; i++) begin
            if (int'(cfg_idx) == i) begin
               wp_addr[i] <= cfg_addr;
               wp_mode[i] <= cfg_mode;
            end
         end
      end
   end

   // Mode bit 1 enables store matches, bit 0 enables load matches.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_WP; i++) begin
         hit[i] = access && (mem_addr == wp_addr[i]) &&
                  (is_write ? wp_mode[i][1] : wp_mode[i][0]);
      end
   end

   assign any_hit = |hit;

   // Descending scan so the lowest hitting channel is the last assignment.
   always_comb begin
      lo_idx = 3'd0;
      for (int i = NUM_WP - 1; i >= 0; i--) begin
         if (hit[i]) lo_idx = 3'(i);
      end
   end

   assign push = access && (!capture_mode || any_hit);
   assign pop  = trace_valid && trace_ready;
   assign drop = push && full && !pop;

   always_comb begin
      in_entry          = '0;
      in_entry.pc       = pc;
      in_entry.addr     = mem_addr;
      in_entry.data     = is_write ? mem_wdata : mem_rdata;
      in_entry.is_write = is_write;
      in_entry.wp_hit   = hit;
   end

   fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (DEPTH),
      .LW    (LW)
   ) u_trace_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (push),
      .push_dat (in_entry),
      .pop_rdy  (trace_ready),
      .head_vld (trace_valid),
      .head_dat (head_raw),
      .level    (trace_level),
      .full     (full)
   );

   // Storage is not reset, so the head fields are forced to zero when empty.
   assign head           = trace_valid ? head_raw : '0;
   assign trace_pc       = head.pc;
   assign trace_addr     = head.addr;
   assign trace_data     = head.data;
   assign trace_is_write = head.is_write;
   assign trace_wp_hit   = head.wp_hit;

   // Saturating drop counter; on a clear edge it restarts from the current drop.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count <= '0;
      end else if (clear) begin
         drop_count <= DROP_W'(drop);
      end else if (drop && (drop_count != {DROP_W{1'b1}})) begin
         drop_count <= drop_count + DROP_W'(1);
      end
   end

   // Sticky halt: only the first hit latches halt_wp. A hit coinciding with
   // clear re-arms immediately, so the hit takes priority over the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         halt_req <= 1'b0;
         halt_wp  <= 3'd0;
      end else if (any_hit && (!halt_req || clear)) begin
         halt_req <= 1'b1;
         halt_wp  <= lo_idx;
      end else if (clear) begin
         halt_req <= 1'b0;
         halt_wp  <= 3'd0;
      end
   end

endmodule

// File: tb/tb_mem_trace_watch.sv
// Directed bench for mem_trace_watch with a queue scoreboard and a pop-side monitor.
// Latency: expected entries are queued at issue; the monitor compares on each accepted pop.
// Backpressure: trace_ready is driven by the stimulus thread to exercise full/drop/wrap cases.
module tb_mem_trace_watch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        capture_mode;
   logic        cfg_we;
   logic [2:0]  cfg_idx;
   logic [31:0] cfg_addr;
   logic [1:0]  cfg_mode;
   logic        clear;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [31:0] trace_addr;
   logic [31:0] trace_data;
   logic        trace_is_write;
   logic [3:0]  trace_wp_hit;
   logic [4:0]  trace_level;
   logic [7:0]  drop_count;
   logic        halt_req;
   logic [2:0]  halt_wp;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
      logic        is_write;
      logic [3:0]  hit;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_trace_watch #(
      .XLEN   (32),
      .DEPTH  (16),
      .NUM_WP (4),
      .DROP_W (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pc             (pc),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .capture_mode   (capture_mode),
      .cfg_we         (cfg_we),
      .cfg_idx        (cfg_idx),
      .cfg_addr       (cfg_addr),
      .cfg_mode       (cfg_mode),
      .clear          (clear),
      .trace_valid    (trace_valid),
      .trace_ready    (trace_ready),
      .trace_pc       (trace_pc),
      .trace_addr     (trace_addr),
      .trace_data     (trace_data),
      .trace_is_write (trace_is_write),
      .trace_wp_hit   (trace_wp_hit),
      .trace_level    (trace_level),
      .drop_count     (drop_count),
      .halt_req       (halt_req),
      .halt_wp        (halt_wp)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: the pop happens on the next rising edge, so the head seen here is the popped entry.
   always @(negedge clk) begin
      if (!reset && trace_valid && trace_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got pc 0x%0h, expected no entry", trace_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pop_pc",       64'(trace_pc),       64'(e.pc));
            chk("pop_addr",     64'(trace_addr),     64'(e.addr));
            chk("pop_data",     64'(trace_data),     64'(e.data));
            chk("pop_is_write", 64'(trace_is_write), 64'(e.is_write));
            chk("pop_wp_hit",   64'(trace_wp_hit),   64'(e.hit));
         end
      end
   end

   // Called at posedge+1; drives one access for exactly one edge and returns at posedge+1.
   task automatic acc(input logic w, input logic r, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rdv,
                      input logic st, input logic [3:0] h);
      exp_t e;
      pc = p; mem_write = w; mem_read = r; mem_addr = a; mem_wdata = wd; mem_rdata = rdv;
      if (st) begin
         e.pc = p; e.addr = a; e.data = w ? wd : rdv; e.is_write = w; e.hit = h;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      mem_write = 1'b0; mem_read = 1'b0;
   endtask

   task automatic cfg(input logic [2:0] idx, input logic [31:0] a, input logic [1:0] m);
      cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_mode = m;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      trace_ready = 1'b1;
      n = 0;
      while ((trace_level != 0 || exp_q.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      trace_ready = 1'b0;
      chk({nm, "_drain_level"}, 64'(trace_level), 64'(0));
      chk({nm, "_drain_queue"}, 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; pc = '0; mem_write = 0; mem_read = 0; mem_addr = '0; mem_wdata = '0;
      mem_rdata = '0; capture_mode = 0; cfg_we = 0; cfg_idx = '0; cfg_addr = '0;
      cfg_mode = '0; clear = 0; trace_ready = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      chk("rst_valid",    64'(trace_valid),    64'(0));
      chk("rst_level",    64'(trace_level),    64'(0));
      chk("rst_drop",     64'(drop_count),     64'(0));
      chk("rst_halt",     64'(halt_req),       64'(0));
      chk("rst_halt_wp",  64'(halt_wp),        64'(0));
      chk("rst_pc",       64'(trace_pc),       64'(0));
      chk("rst_data",     64'(trace_data),     64'(0));
      chk("rst_is_write", 64'(trace_is_write), 64'(0));

      // Store then load, record-all mode
      acc(1, 0, 32'h08, 32'h10, 32'hDEADBEEF, 32'h0, 1, 4'b0000);
      chk("t1_first_valid", 64'(trace_valid), 64'(1));
      acc(0, 1, 32'h0C, 32'h10, 32'h0, 32'hDEADBEEF, 1, 4'b0000);
      chk("t1_level",    64'(trace_level),    64'(2));
      chk("t1_head_pc",  64'(trace_pc),       64'(32'h08));
      chk("t1_head_adr", 64'(trace_addr),     64'(32'h10));
      chk("t1_head_dat", 64'(trace_data),     64'(32'hDEADBEEF));
      chk("t1_head_wr",  64'(trace_is_write), 64'(1));
      trace_ready = 1'b1;
      @(posedge clk); #1;
      trace_ready = 1'b0;
      chk("t1_pop_level", 64'(trace_level),    64'(1));
      chk("t1_pop_wr",    64'(trace_is_write), 64'(0));
      chk("t1_pop_pc",    64'(trace_pc),       64'(32'h0C));
      drain("t1");

      // Watchpoint 1 on stores to 0x20, hits-only capture
      cfg(3'd1, 32'h20, 2'b10);
      capture_mode = 1'b1;
      acc(0, 1, 32'h40, 32'h20, 32'h0, 32'h11, 0, 4'b0000);
      chk("t2_load_nohalt", 64'(halt_req), 64'(0));
      acc(1, 0, 32'h44, 32'h24, 32'h22, 32'h0, 0, 4'b0000);
      chk("t2_level0", 64'(trace_level), 64'(0));
      acc(1, 0, 32'h48, 32'h20, 32'h33, 32'h0, 1, 4'b0010);
      chk("t2_level1",  64'(trace_level), 64'(1));
      chk("t2_halt",    64'(halt_req),    64'(1));
      chk("t2_halt_wp", 64'(halt_wp),     64'(1));
      chk("t2_hitvec",  64'(trace_wp_hit), 64'(4'b0010));
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("t2_clear", 64'(halt_req), 64'(0));
      drain("t2");
      cfg(3'd1, 32'h0, 2'b00);
      capture_mode = 1'b0;

      // Overflow: 20 stores into 16 entries, then 20 more while draining each cycle
      for (int i = 0; i < 20; i++)
         acc(1, 0, 32'h100 + 32'(4*i), 32'h1000 + 32'(4*i), 32'(i), 32'h0, (i < 16), 4'b0000);
      chk("t3_level",   64'(trace_level), 64'(16));
      chk("t3_drop",    64'(drop_count),  64'(4));
      chk("t3_head_pc", 64'(trace_pc),    64'(32'h100));
      trace_ready = 1'b1;
      for (int i = 20; i < 40; i++)
         acc(1, 0, 32'h100 + 32'(4*i), 32'h1000 + 32'(4*i), 32'(i), 32'h0, 1, 4'b0000);
      chk("t3_level_full", 64'(trace_level), 64'(16));
      chk("t3_drop_hold",  64'(drop_count),  64'(4));
      drain("t3");

      // Both strobes high is a store
      acc(1, 1, 32'h200, 32'h30, 32'h5, 32'h9, 1, 4'b0000);
      chk("t4_wr",   64'(trace_is_write), 64'(1));
      chk("t4_data", 64'(trace_data),     64'(32'h5));
      drain("t4");

      // Config write in the same cycle as a matching access does not hit
      cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 32'h40; cfg_mode = 2'b11;
      acc(0, 1, 32'h300, 32'h40, 32'h0, 32'h77, 1, 4'b0000);
      cfg_we = 1'b0;
      chk("t5_same_cycle_nohalt", 64'(halt_req), 64'(0));
      acc(0, 1, 32'h304, 32'h40, 32'h0, 32'h78, 1, 4'b0001);
      chk("t5_halt",    64'(halt_req),    64'(1));
      chk("t5_halt_wp", 64'(halt_wp),     64'(0));
      chk("t5_level",   64'(trace_level), 64'(2));
      for (int i = 0; i < 3; i++)
         acc(1, 0, 32'h308 + 32'(4*i), 32'h50 + 32'(4*i), 32'(i), 32'h0, 1, 4'b0000);
      chk("t5_level5", 64'(trace_level), 64'(5));

      // Reset mid-operation with an access presented during reset
      reset = 1'b1; mem_write = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hAA; pc = 32'h400;
      @(posedge clk); #1;
      reset = 1'b0; mem_write = 1'b0;
      exp_q.delete();
      chk("t6_valid", 64'(trace_valid), 64'(0));
      chk("t6_level", 64'(trace_level), 64'(0));
      chk("t6_halt",  64'(halt_req),    64'(0));
      chk("t6_drop",  64'(drop_count),  64'(0));
      capture_mode = 1'b1;
      acc(0, 1, 32'h404, 32'h40, 32'h0, 32'h1, 0, 4'b0000);
      chk("t6_old_wp_level", 64'(trace_level), 64'(0));
      chk("t6_old_wp_halt",  64'(halt_req),    64'(0));
      capture_mode = 1'b0;
      acc(1, 0, 32'h408, 32'h60, 32'hBB, 32'h0, 1, 4'b0000);
      drain("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
